// File: rtl/pq_pkg.sv
// Shared types and index helpers for the pq family of heap priority queues.
// Heap indices are 1-based: children of i are 2i and 2i+1, parent is i/2.
package pq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ENQ_WR,
        ENQ_RDP,
        ENQ_CMP,
        ENQ_SWP2,
        DEQ_RD,
        DEQ_WR,
        REPL_WR,
        HP_ST,
        HP_RDL,
        HP_RDR,
        HP_SWP,
        HP_SWP2
    } heap_st_t;

    // Wide generic index; callers size-cast the result to their own index width.
    localparam int HP_IDX_W = 32;
    typedef logic [HP_IDX_W-1:0] hp_idx_t;

    function automatic hp_idx_t hp_left(input hp_idx_t i);
        return {i[HP_IDX_W-2:0], 1'b0};
    endfunction

    function automatic hp_idx_t hp_right(input hp_idx_t i);
        return {i[HP_IDX_W-2:0], 1'b1};
    endfunction

    function automatic hp_idx_t hp_parent(input hp_idx_t i);
        return {1'b0, i[HP_IDX_W-1:1]};
    endfunction

endpackage

// File: rtl/mem_swsr.sv
// Single-port RAM with synchronous write and registered (one-cycle) read.
// Read-during-write returns the previous contents of the addressed word.
module mem_swsr #(
    parameter int W  = 8,
    parameter int D  = 16,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem [D];

    // NOTE: the array has no reset so it maps onto RAM macros; callers never read unwritten words.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/heap_pq_gen.sv
// Binary-heap priority queue (min- or max-heap) over a single-port RAM.
// Define HEAP_PQ_GEN_ERR_EN to add a sticky err flag for dropped requests.
module heap_pq_gen
    import pq_pkg::*;
#(
    parameter int KW       = 8,
    parameter int VW       = 8,
    parameter int DEPTH    = 16,
    parameter int MAX_HEAP = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [KW+VW-1:0]           kvi,
    output logic [KW+VW-1:0]           kvo,
    output logic                       kvo_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef HEAP_PQ_GEN_ERR_EN
    ,
    output logic                       err,
    input  logic                       err_clr
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = CW + 1;
    localparam int AW = CW;
    localparam int W  = KW + VW;
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [IW-1:0] ONE_I = IW'(1);
    localparam logic [AW-1:0] ROOT  = AW'(1);

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] val;
    } kv_t;

    function automatic logic prio(input kv_t a, input kv_t b);
        return (MAX_HEAP != 0) ? (a.key > b.key) : (a.key < b.key);
    endfunction

    heap_st_t      state, state_nx;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx, best, cnt_x;
    logic [IW-1:0] left_i, right_i, parent_i;
    kv_t           mov, oth, kvo_q, rd;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_din, ram_dout;
    logic          do_repl, do_enq, do_deq;

    assign cnt_x    = {1'b0, cnt};
    assign left_i   = IW'(hp_left(hp_idx_t'(idx)));
    assign right_i  = IW'(hp_right(hp_idx_t'(idx)));
    assign parent_i = IW'(hp_parent(hp_idx_t'(idx)));
    assign rd       = kv_t'(ram_dout);

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign kvo_valid = !empty;
    assign busy      = (state != IDLE);
    assign count     = cnt;
    assign kvo       = kvo_q;

    assign do_repl = enq && deq && !empty;
    assign do_enq  = !do_repl && enq && !full;
    assign do_deq  = !do_repl && !do_enq && deq && !empty;

    mem_swsr #(.W(W), .D(DEPTH+1), .AW(AW)) u_mem (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (do_repl)     state_nx = REPL_WR;
                else if (do_enq) state_nx = ENQ_WR;
                else if (do_deq) state_nx = DEQ_RD;
            end
            ENQ_WR:   state_nx = (cnt == '0) ? IDLE : ENQ_RDP;
            ENQ_RDP:  state_nx = ENQ_CMP;
            ENQ_CMP:  state_nx = prio(mov, rd) ? ENQ_SWP2 : IDLE;
            ENQ_SWP2: state_nx = (parent_i == ONE_I) ? IDLE : ENQ_RDP;
            DEQ_RD:   state_nx = DEQ_WR;
            DEQ_WR:   state_nx = (cnt == '0) ? IDLE : HP_ST;
            REPL_WR:  state_nx = HP_ST;
            HP_ST:    state_nx = (left_i > cnt_x) ? IDLE : HP_RDL;
            HP_RDL:   state_nx = (right_i <= cnt_x) ? HP_RDR : HP_SWP;
            HP_RDR:   state_nx = HP_SWP;
            HP_SWP:   state_nx = (best == idx) ? IDLE : HP_SWP2;
            HP_SWP2:  state_nx = HP_ST;
            default:  state_nx = IDLE;
        endcase
    end

    // RAM port: one read or one write per cycle.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = mov;
        unique case (state)
            ENQ_WR:  begin ram_we = 1'b1; ram_addr = cnt + ONE_C; end
            ENQ_RDP: ram_addr = AW'(parent_i);
            ENQ_CMP: begin
                ram_addr = AW'(parent_i);
                ram_we   = prio(mov, rd);
            end
            ENQ_SWP2: begin ram_we = 1'b1; ram_addr = AW'(idx); ram_din = oth; end
            DEQ_RD:   ram_addr = cnt;
            DEQ_WR: begin
                ram_we   = (cnt != '0);
                ram_addr = ROOT;
                ram_din  = rd;
            end
            REPL_WR: begin ram_we = 1'b1; ram_addr = ROOT; end
            HP_ST:   if (left_i <= cnt_x) ram_addr = AW'(left_i);
            HP_RDL:  if (right_i <= cnt_x) ram_addr = AW'(right_i);
            HP_SWP: begin
                ram_we   = (best != idx);
                ram_addr = AW'(idx);
                ram_din  = oth;
            end
            HP_SWP2: begin ram_we = 1'b1; ram_addr = AW'(best); end
            default: ;
        endcase
    end

    // kvo mirrors every write to the root so it never needs a RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            kvo_q <= '0;
        end else begin
            if (state == ENQ_WR) cnt <= cnt + ONE_C;
            if (state == DEQ_RD) cnt <= cnt - ONE_C;
            if (ram_we && ram_addr == ROOT) kvo_q <= kv_t'(ram_din);
        end
    end

    // mov is the entry being sifted; oth holds the parent (sift-up) or best child (heapify).
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE:     mov <= kv_t'(kvi);
            ENQ_WR:   idx <= IW'(cnt) + ONE_I;
            ENQ_CMP:  oth <= rd;
            ENQ_SWP2: idx <= parent_i;
            DEQ_WR: begin
                mov <= rd;
                idx <= ONE_I;
            end
            REPL_WR:  idx <= ONE_I;
            HP_ST: begin
                best <= idx;
                oth  <= mov;
            end
            HP_RDL: if (prio(rd, oth)) begin
                best <= left_i;
                oth  <= rd;
            end
            HP_RDR: if (prio(rd, oth)) begin
                best <= right_i;
                oth  <= rd;
            end
            HP_SWP2:  idx <= best;
            default: ;
        endcase
    end

`ifdef HEAP_PQ_GEN_ERR_EN
    logic drop;
    assign drop = (state == IDLE) &&
                  ((enq && !deq && full) || (deq && !enq && empty));

    always_ff @(posedge clk) begin
        if (rst)          err <= 1'b0;
        else if (drop)    err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_heap_pq_gen.sv
// Self-checking bench: a min-heap and a max-heap instance driven in lockstep,
// compared against a multiset model of queue contents.
module tb_heap_pq_gen;

    localparam int KW = 8;
    localparam int VW = 8;
    localparam int DEPTH = 16;
    localparam int LG = 4;
    localparam int ENQ_BOUND = 1 + 3 * LG;
    localparam int DQ_BOUND = 2 + 5 * LG;

    typedef logic [KW+VW-1:0] ent_t;

    logic clk = 1'b0;
    logic rst, enq, deq;
    ent_t kvi;
    ent_t kvo0, kvo1;
    logic valid0, valid1, full0, full1, empty0, empty1, busy0, busy1;
    logic [4:0] count0, count1;
`ifdef HEAP_PQ_GEN_ERR_EN
    logic err0, err1, err_clr;
    bit   exp_err;
`endif

    int checks = 0;
    int errors = 0;
    ent_t m0[$];
    ent_t m1[$];

    always #5 clk = ~clk;

    heap_pq_gen #(.KW(KW), .VW(VW), .DEPTH(DEPTH), .MAX_HEAP(0)) dut0 (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo0),
        .kvo_valid(valid0), .full(full0), .empty(empty0), .busy(busy0), .count(count0)
`ifdef HEAP_PQ_GEN_ERR_EN
        , .err(err0), .err_clr(err_clr)
`endif
    );

    heap_pq_gen #(.KW(KW), .VW(VW), .DEPTH(DEPTH), .MAX_HEAP(1)) dut1 (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo1),
        .kvo_valid(valid1), .full(full1), .empty(empty1), .busy(busy1), .count(count1)
`ifdef HEAP_PQ_GEN_ERR_EN
        , .err(err1), .err_clr(err_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_idx(input ent_t q[$], input ent_t e);
        foreach (q[k]) if (q[k] == e) return k;
        return -1;
    endfunction

    function automatic logic [KW-1:0] best_key(input ent_t q[$], input bit maxh);
        logic [KW-1:0] b;
        b = q[0][KW+VW-1:VW];
        foreach (q[k]) begin
            if (maxh ? (q[k][KW+VW-1:VW] > b) : (q[k][KW+VW-1:VW] < b)) b = q[k][KW+VW-1:VW];
        end
        return b;
    endfunction

    task automatic verify();
        check("count0", 32'(count0), 32'(m0.size()));
        check("count1", 32'(count1), 32'(m1.size()));
        check("empty0", 32'(empty0), 32'(m0.size() == 0));
        check("full0", 32'(full0), 32'(m0.size() == DEPTH));
        check("valid0", 32'(valid0), 32'(m0.size() != 0));
        check("valid1", 32'(valid1), 32'(m1.size() != 0));
        if (m0.size() > 0) begin
            check("kvo0_key", 32'(kvo0[KW+VW-1:VW]), 32'(best_key(m0, 1'b0)));
            check("kvo0_entry", 32'(find_idx(m0, kvo0) >= 0), 32'd1);
        end
        if (m1.size() > 0) begin
            check("kvo1_key", 32'(kvo1[KW+VW-1:VW]), 32'(best_key(m1, 1'b1)));
            check("kvo1_entry", 32'(find_idx(m1, kvo1) >= 0), 32'd1);
        end
`ifdef HEAP_PQ_GEN_ERR_EN
        check("err0", 32'(err0), 32'(exp_err));
        check("err1", 32'(err1), 32'(exp_err));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m0.delete();
        m1.delete();
`ifdef HEAP_PQ_GEN_ERR_EN
        exp_err = 1'b0;
`endif
    endtask

    task automatic wait_idle(output int n0, output int n1);
        int guard;
        n0 = 0;
        n1 = 0;
        guard = 0;
        while ((busy0 || busy1) && guard < 100) begin
            n0 += int'(busy0);
            n1 += int'(busy1);
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic cmd(input bit e, input bit d, input ent_t kv);
        int n0, n1, sz, ia, ib, bound;
        ent_t r0, r1;
        bit is_repl, is_enq, is_deq;
        wait_idle(n0, n1);
        if (busy0 || busy1) check("idle_wait", 32'({busy0, busy1}), 32'd0);
        r0 = kvo0;
        r1 = kvo1;
        sz = m0.size();
        is_repl = e && d && sz > 0;
        is_enq  = !is_repl && e && sz < DEPTH;
        is_deq  = !is_repl && !is_enq && d && sz > 0;
`ifdef HEAP_PQ_GEN_ERR_EN
        if ((e && !d && sz == DEPTH) || (d && !e && sz == 0)) exp_err = 1'b1;
`endif
        enq = e;
        deq = d;
        kvi = kv;
        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        wait_idle(n0, n1);
        check("op_done", 32'({busy0, busy1}), 32'd0);
        bound = is_enq ? ENQ_BOUND : DQ_BOUND;
        if (is_enq || is_deq || is_repl) begin
            check("latency0", 32'(n0 <= bound), 32'd1);
            check("latency1", 32'(n1 <= bound), 32'd1);
        end else begin
            check("dropped_idle", 32'(n0 + n1), 32'd0);
        end
        if (is_deq || is_repl) begin
            ia = find_idx(m0, r0);
            ib = find_idx(m1, r1);
            check("root0_known", 32'(ia >= 0), 32'd1);
            check("root1_known", 32'(ib >= 0), 32'd1);
            if (ia >= 0) m0.delete(ia);
            if (ib >= 0) m1.delete(ib);
        end
        if (is_enq || is_repl) begin
            m0.push_back(kv);
            m1.push_back(kv);
        end
        verify();
    endtask

    task automatic drain();
        while (m0.size() > 0) cmd(1'b0, 1'b1, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_min[5];
        int exp_max[5];
        int keys[5];
        int n0, n1;
        ent_t tie0[3];
        ent_t tie1[3];
        exp_min = '{1, 3, 5, 7, 9};
        exp_max = '{9, 7, 5, 3, 1};
        keys = '{9, 3, 7, 1, 5};
        tie0 = '{16'h020C, 16'h050A, 16'h050B};
        tie1 = '{16'h050A, 16'h050B, 16'h020C};
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        kvi = '0;
`ifdef HEAP_PQ_GEN_ERR_EN
        err_clr = 1'b0;
        exp_err = 1'b0;
`endif
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_count", 32'(count0), 32'd0);
        check("rst_kvo", 32'(kvo0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_full", 32'(full0), 32'd0);
        check("rst_busy", 32'({busy0, busy1}), 32'd0);

        // Min/max ordering
        foreach (keys[k]) cmd(1'b1, 1'b0, ent_t'({8'(keys[k]), 8'(8'h10 + k)}));
        check("min_root", 32'(kvo0[15:8]), 32'd1);
        check("max_root", 32'(kvo1[15:8]), 32'd9);
        check("five_count", 32'(count0), 32'd5);
        for (int j = 0; j < 5; j++) begin
            check("min_seq", 32'(kvo0[15:8]), 32'(exp_min[j]));
            check("max_seq", 32'(kvo1[15:8]), 32'(exp_max[j]));
            cmd(1'b0, 1'b1, '0);
        end
        check("drained_empty", 32'(empty0), 32'd1);
        check("drained_valid", 32'(valid0), 32'd0);

        // Full queue: drop plain enq, accept replace
        for (int k = 20; k <= 35; k++) cmd(1'b1, 1'b0, ent_t'({8'(k), 8'(k)}));
        check("full_flag", 32'(full0), 32'd1);
        cmd(1'b1, 1'b0, 16'h00AA);
        check("full_drop_count", 32'(count0), 32'd16);
        cmd(1'b1, 1'b1, 16'h00BB);
        check("repl_root", 32'(kvo0[15:8]), 32'd0);
        check("repl_count", 32'(count0), 32'd16);
        drain();

        // enq&deq on empty behaves as enq
        cmd(1'b1, 1'b1, 16'h0444);
        check("empty_ed_count", 32'(count0), 32'd1);
        check("empty_ed_root", 32'(kvo0[15:8]), 32'd4);
        drain();

        // Ties keep insertion order on the way up
        cmd(1'b1, 1'b0, 16'h050A);
        cmd(1'b1, 1'b0, 16'h050B);
        cmd(1'b1, 1'b0, 16'h020C);
        for (int j = 0; j < 3; j++) begin
            check("tie_min", 32'(kvo0), 32'(tie0[j]));
            check("tie_max", 32'(kvo1), 32'(tie1[j]));
            cmd(1'b0, 1'b1, '0);
        end

        // Reset in the middle of heapify
        for (int k = 0; k < 8; k++) cmd(1'b1, 1'b0, ent_t'({8'($urandom_range(0, 50)), 8'(k)}));
        wait_idle(n0, n1);
        deq = 1'b1;
        @(negedge clk);
        deq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy0), 32'd1);
        do_reset();
        check("midrst_count", 32'(count0), 32'd0);
        check("midrst_busy", 32'({busy0, busy1}), 32'd0);
        check("midrst_kvo", 32'(kvo0), 32'd0);
        check("midrst_valid", 32'(valid0), 32'd0);
        cmd(1'b1, 1'b0, 16'h0601);
        check("post_rst_root", 32'(kvo0[15:8]), 32'd6);
        drain();

`ifdef HEAP_PQ_GEN_ERR_EN
        cmd(1'b0, 1'b1, '0);
        check("err_set", 32'(err0), 32'd1);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err0), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr", 32'(err0), 32'd0);
`endif

        // Random traffic with many duplicate keys
        for (int t = 0; t < 400; t++) begin
            int r;
            ent_t kv;
            r = int'($urandom_range(0, 9));
            kv = ent_t'({8'($urandom_range(0, 15)), 8'($urandom)});
            if (r < 5)      cmd(1'b1, 1'b0, kv);
            else if (r < 8) cmd(1'b0, 1'b1, kv);
            else            cmd(1'b1, 1'b1, kv);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
